// File: rtl/multi_ctrl.sv
// Multi-cycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing,
// datapath select generation and a retired-instruction counter.
module multi_ctrl #(
  parameter int ALUOP_W     = 5,
  parameter int MEM_WAIT_EN = 1,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_rdy,
  output logic               IMRd,
  output logic               IRWr,
  output logic               PCWr,
  output logic               RFWr,
  output logic               DMRd,
  output logic               DMWr,
  output logic               MemtoReg,
  output logic [1:0]         EXTOp,
  output logic [1:0]         NPCOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         RegDst,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         state,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4;

  localparam logic [ALUOP_W-1:0] ALU_NOP  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_ADDU = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_SUBU = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_EQL  = ALUOP_W'(11);
  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(17);
  localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(18);
  localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(19);

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_SLL, C_SRL, C_SRA, C_JR, C_ORI, C_LUI,
    C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
  } cls_t;

  function automatic cls_t decode(input logic [5:0] op, input logic [5:0] funct);
    cls_t c;
    c = C_ILL;
    case (op)
      6'h00: case (funct)
        6'h21: c = C_ADDU;
        6'h23: c = C_SUBU;
        6'h00: c = C_SLL;
        6'h02: c = C_SRL;
        6'h03: c = C_SRA;
        6'h08: c = C_JR;
        default: c = C_ILL;
      endcase
      6'h0D: c = C_ORI;
      6'h0F: c = C_LUI;
      6'h23: c = C_LW;
      6'h2B: c = C_SW;
      6'h04: c = C_BEQ;
      6'h02: c = C_J;
      6'h03: c = C_JAL;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  logic [2:0] state_q, state_nxt;
  cls_t       cls_q, cls_cur;
  logic       mem_done;

  assign mem_done = mem_rdy | (MEM_WAIT_EN == 0);
  // The IR is decoded live in DECODE and the class is held for later states.
  assign cls_cur  = (state_q == S_DECODE) ? decode(Op, Funct) : cls_q;
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_ILL;
      retired <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == S_DECODE) cls_q <= cls_cur;
      if (PCWr) retired <= retired + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_FETCH:  if (mem_done) state_nxt = S_DECODE;
      S_DECODE: case (cls_cur)
        C_J, C_JR, C_ILL: state_nxt = S_FETCH;
        C_JAL:            state_nxt = S_WB;
        default:          state_nxt = S_EXEC;
      endcase
      S_EXEC: case (cls_cur)
        C_LW, C_SW: state_nxt = S_MEM;
        C_BEQ:      state_nxt = S_FETCH;
        default:    state_nxt = S_WB;
      endcase
      S_MEM:    if (mem_done) state_nxt = (cls_cur == C_LW) ? S_WB : S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    IMRd = 1'b0; IRWr = 1'b0; PCWr = 1'b0; RFWr = 1'b0;
    DMRd = 1'b0; DMWr = 1'b0; MemtoReg = 1'b0; illegal = 1'b0;
    EXTOp = 2'd0; NPCOp = 2'd0; ALUOp = ALU_NOP;
    RegDst = 2'd0; ALUSrcA = 2'd0; ALUSrcB = 2'd0;
    if (!rst) begin
      // Selects stay constant from EXEC through the instruction's final state.
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
        case (cls_cur)
          C_ADDU: begin ALUOp = ALU_ADDU; RegDst = 2'd1; end
          C_SUBU: begin ALUOp = ALU_SUBU; RegDst = 2'd1; end
          C_SLL:  begin ALUOp = ALU_SLL; RegDst = 2'd1; ALUSrcA = 2'd1; ALUSrcB = 2'd1; end
          C_SRL:  begin ALUOp = ALU_SRL; RegDst = 2'd1; ALUSrcA = 2'd1; ALUSrcB = 2'd1; end
          C_SRA:  begin ALUOp = ALU_SRA; RegDst = 2'd1; ALUSrcA = 2'd1; ALUSrcB = 2'd1; end
          C_ORI:  begin ALUOp = ALU_OR; EXTOp = 2'd1; ALUSrcB = 2'd1; end
          C_LUI:  begin ALUOp = ALU_NOP; EXTOp = 2'd2; ALUSrcB = 2'd1; end
          C_LW, C_SW: begin ALUOp = ALU_ADD; ALUSrcB = 2'd1; end
          C_BEQ:  ALUOp = ALU_EQL;
          C_JAL:  begin ALUOp = ALU_ADDU; RegDst = 2'd2; ALUSrcA = 2'd2; ALUSrcB = 2'd2; end
          default: ;
        endcase
      end
      case (state_q)
        S_FETCH: begin IMRd = 1'b1; IRWr = mem_done; end
        S_DECODE: case (cls_cur)
          C_J:   begin PCWr = 1'b1; NPCOp = 2'd2; end
          C_JR:  begin PCWr = 1'b1; NPCOp = 2'd3; end
          C_ILL: begin PCWr = 1'b1; illegal = 1'b1; end
          default: ;
        endcase
        S_EXEC: if (cls_cur == C_BEQ) begin
          PCWr  = 1'b1;
          NPCOp = Zero ? 2'd1 : 2'd0;
        end
        S_MEM: begin
          DMRd = (cls_cur == C_LW);
          DMWr = (cls_cur == C_SW);
          PCWr = (cls_cur == C_SW) && mem_done;
        end
        S_WB: begin
          RFWr     = 1'b1;
          PCWr     = 1'b1;
          MemtoReg = (cls_cur == C_LW);
          if (cls_cur == C_JAL) NPCOp = 2'd2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_ctrl.sv
// Randomized bench for multi_ctrl: each instruction is expanded into its
// expected phase path and every cycle's outputs are checked against that path.
module tb_multi_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, Zero, mem_rdy;
  logic [5:0] Op, Funct;
  logic IMRd, IRWr, PCWr, RFWr, DMRd, DMWr, MemtoReg, illegal;
  logic [1:0] EXTOp, NPCOp, RegDst, ALUSrcA, ALUSrcB;
  logic [4:0] ALUOp;
  logic [2:0] state;
  logic [31:0] retired;

  logic rst2, Zero2, mem_rdy2;
  logic [5:0] Op2, Funct2;
  logic IMRd2, IRWr2, PCWr2, RFWr2, DMRd2, DMWr2, MemtoReg2, illegal2;
  logic [1:0] EXTOp2, NPCOp2, RegDst2, ALUSrcA2, ALUSrcB2;
  logic [4:0] ALUOp2;
  logic [2:0] state2;
  logic [3:0] retired2;

  multi_ctrl dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_rdy(mem_rdy),
    .IMRd(IMRd), .IRWr(IRWr), .PCWr(PCWr), .RFWr(RFWr), .DMRd(DMRd), .DMWr(DMWr),
    .MemtoReg(MemtoReg), .EXTOp(EXTOp), .NPCOp(NPCOp), .ALUOp(ALUOp), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .state(state), .illegal(illegal), .retired(retired)
  );

  multi_ctrl #(.ALUOP_W(5), .MEM_WAIT_EN(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .Op(Op2), .Funct(Funct2), .Zero(Zero2), .mem_rdy(mem_rdy2),
    .IMRd(IMRd2), .IRWr(IRWr2), .PCWr(PCWr2), .RFWr(RFWr2), .DMRd(DMRd2), .DMWr(DMWr2),
    .MemtoReg(MemtoReg2), .EXTOp(EXTOp2), .NPCOp(NPCOp2), .ALUOp(ALUOp2), .RegDst(RegDst2),
    .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .state(state2), .illegal(illegal2), .retired(retired2)
  );

  localparam int ADDU = 0, SUBU = 1, SLL = 2, SRL = 3, SRA = 4, JR = 5, ORI = 6, LUI = 7,
                 LW = 8, SW = 9, BEQ = 10, J = 11, JAL = 12, ILL = 13;
  localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4;
  localparam int A_NOP = 0, A_ADDU = 1, A_ADD = 2, A_SUBU = 3, A_OR = 6, A_EQL = 11,
                 A_SLL = 17, A_SRL = 18, A_SRA = 19;

  int n_vec = 0, n_err = 0;
  int unsigned ret_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full instruction; flat/mlat = low mem_rdy cycles before ready (-1 = random).
  task automatic run_instr(input int c, input int flat, input int mlat, input bit z,
                           output int cycles);
    int path[$];
    logic [5:0] op, fn;
    int e_ext, e_alu, e_a, e_b, e_rd, waited, p;
    bit adv, last, pcw;
    fn = 6'($urandom);
    case (c)
      ADDU: begin op = 6'h00; fn = 6'h21; end
      SUBU: begin op = 6'h00; fn = 6'h23; end
      SLL:  begin op = 6'h00; fn = 6'h00; end
      SRL:  begin op = 6'h00; fn = 6'h02; end
      SRA:  begin op = 6'h00; fn = 6'h03; end
      JR:   begin op = 6'h00; fn = 6'h08; end
      ORI:  op = 6'h0D;
      LUI:  op = 6'h0F;
      LW:   op = 6'h23;
      SW:   op = 6'h2B;
      BEQ:  op = 6'h04;
      J:    op = 6'h02;
      JAL:  op = 6'h03;
      default: case ($urandom_range(0, 3))
        0: op = 6'h3F;
        1: op = 6'h08;
        2: begin op = 6'h00; fn = 6'h20; end
        default: begin op = 6'h00; fn = 6'h2A; end
      endcase
    endcase
    path = '{PF, PD};
    case (c)
      J, JR, ILL: ;
      JAL: path.push_back(PW);
      BEQ: path.push_back(PE);
      LW:  begin path.push_back(PE); path.push_back(PM); path.push_back(PW); end
      SW:  begin path.push_back(PE); path.push_back(PM); end
      default: begin path.push_back(PE); path.push_back(PW); end
    endcase
    e_ext = 0; e_alu = A_NOP; e_a = 0; e_b = 0; e_rd = 0;
    case (c)
      ADDU: begin e_alu = A_ADDU; e_rd = 1; end
      SUBU: begin e_alu = A_SUBU; e_rd = 1; end
      SLL:  begin e_alu = A_SLL; e_rd = 1; e_a = 1; e_b = 1; end
      SRL:  begin e_alu = A_SRL; e_rd = 1; e_a = 1; e_b = 1; end
      SRA:  begin e_alu = A_SRA; e_rd = 1; e_a = 1; e_b = 1; end
      ORI:  begin e_alu = A_OR; e_ext = 1; e_b = 1; end
      LUI:  begin e_alu = A_NOP; e_ext = 2; e_b = 1; end
      LW, SW: begin e_alu = A_ADD; e_b = 1; end
      BEQ:  e_alu = A_EQL;
      JAL:  begin e_alu = A_ADDU; e_rd = 2; e_a = 2; e_b = 2; end
      default: ;
    endcase
    cycles = 0;
    for (int k = 0; k < path.size(); k++) begin
      p = path[k];
      last = (k == path.size() - 1);
      waited = 0;
      adv = 1'b0;
      while (!adv) begin
        if (p == PF) begin
          Op = 6'($urandom); Funct = 6'($urandom);
          mem_rdy = (flat < 0) ? 1'($urandom) : (waited >= flat);
        end else begin
          Op = op; Funct = fn;
          mem_rdy = (p == PM) ? ((mlat < 0) ? 1'($urandom) : (waited >= mlat)) : 1'($urandom);
        end
        Zero = (p == PE) ? z : 1'($urandom);
        #1;
        adv = (p == PF || p == PM) ? mem_rdy : 1'b1;
        pcw = last && adv;
        chk("state", 32'(state), 32'(p));
        chk("retired", retired, ret_m);
        chk("IMRd", 32'(IMRd), 32'(p == PF));
        chk("IRWr", 32'(IRWr), 32'(p == PF && adv));
        chk("PCWr", 32'(PCWr), 32'(pcw));
        chk("RFWr", 32'(RFWr), 32'(p == PW));
        chk("DMRd", 32'(DMRd), 32'(p == PM && c == LW));
        chk("DMWr", 32'(DMWr), 32'(p == PM && c == SW));
        chk("MemtoReg", 32'(MemtoReg), 32'(p == PW && c == LW));
        chk("illegal", 32'(illegal), 32'(p == PD && c == ILL));
        chk("NPCOp", 32'(NPCOp), !pcw ? 0 : (c == J || c == JAL) ? 2 : (c == JR) ? 3 :
                                  (c == BEQ) ? 32'(z) : 0);
        chk("EXTOp", 32'(EXTOp), (p >= PE) ? e_ext : 0);
        chk("ALUOp", 32'(ALUOp), (p >= PE) ? e_alu : 0);
        chk("ALUSrcA", 32'(ALUSrcA), (p >= PE) ? e_a : 0);
        chk("ALUSrcB", 32'(ALUSrcB), (p >= PE) ? e_b : 0);
        chk("RegDst", 32'(RegDst), (p >= PE) ? e_rd : 0);
        @(posedge clk); #1;
        if (pcw) ret_m++;
        waited++;
        cycles++;
      end
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1; Op = '0; Funct = '0; Zero = 1'b0; mem_rdy = 1'b0;
    rst2 = 1'b1; Op2 = 6'h02; Funct2 = '0; Zero2 = 1'b0; mem_rdy2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_retired", retired, 0);
    chk("rst_IMRd", 32'(IMRd), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_state", 32'(state), 0);
    chk("post_rst_IMRd", 32'(IMRd), 1);

    run_instr(ADDU, 0, 0, 1'b0, cyc);
    chk("addu_cycles", 32'(cyc), 4);
    chk("addu_retired", retired, 1);
    run_instr(LW, 0, 3, 1'b0, cyc);
    chk("lw_cycles", 32'(cyc), 8);
    run_instr(BEQ, 0, 0, 1'b1, cyc);
    chk("beq1_cycles", 32'(cyc), 3);
    run_instr(BEQ, 0, 0, 1'b0, cyc);
    chk("beq0_cycles", 32'(cyc), 3);
    run_instr(JAL, 0, 0, 1'b0, cyc);
    chk("jal_cycles", 32'(cyc), 3);
    run_instr(ILL, 0, 0, 1'b0, cyc);
    chk("ill_cycles", 32'(cyc), 2);
    for (int i = 0; i < 14; i++) run_instr(i, -1, -1, 1'($urandom), cyc);
    for (int i = 0; i < 60; i++) run_instr($urandom_range(0, 13), -1, -1, 1'($urandom), cyc);

    // Reset taken in the middle of a stalled store.
    Op = 6'h2B; Funct = '0; mem_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_rdy = 1'b0;
    #1;
    chk("sw_mem_state", 32'(state), 3);
    chk("sw_mem_DMWr", 32'(DMWr), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ret_m = 0;
    #1;
    chk("sw_rst_DMWr", 32'(DMWr), 0);
    chk("sw_rst_state", 32'(state), 0);
    chk("sw_rst_retired", retired, 0);
    chk("sw_rst_IMRd", 32'(IMRd), 1);

    // 4-bit counter, memory wait disabled: each J retires in 2 cycles.
    rst2 = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      repeat (2) @(posedge clk);
      #1;
      chk("wrap_retired", 32'(retired2), 32'(k % 16));
      chk("wrap_state", 32'(state2), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
